// File: rtl/rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rx_packet_ctrl
//  Description : Packet framing controller placed after the UART receiver.
//                It hunts for SYNC, then takes LEN, PAYLOAD[LEN] and CHK, and
//                checks the XOR checksum. A verified payload is held in the
//                buffer and offered to the consumer with a ready/ack
//                handshake. Bad length, bad checksum and inter-byte timeout
//                each abort the packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_packet_ctrl #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  // Derived widths; these are not meant to be overridden.
  localparam int        LW             = $clog2(MAX_LEN + 1),
  localparam int        AW             = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          reset,        // asynchronous, active low
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [LW-1:0] pkt_len,
  output logic          pkt_ready,
  input  logic          pkt_ack,
  output logic          chk_err,
  output logic          len_err,
  output logic          timeout_err,
  output logic          drop
);

  // The idle counter only has to reach TIMEOUT_CYCLES-2: the timeout fires
  // in the byte-free cycle whose count step would make it TIMEOUT_CYCLES-1.
  localparam int              CW        = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES - 1) : 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [8:0]      MAX_LEN_B = 9'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    GET_LEN     = 3'd1,
    GET_PAYLOAD = 3'd2,
    GET_CHK     = 3'd3,
    HOLD        = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_nx;

  logic [LW-1:0]   len_q;
  logic [LW-1:0]   len_nx;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   idx_nx;
  logic [7:0]      chk_q;
  logic [7:0]      chk_nx;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_nx;

  logic [LW-1:0]   pkt_len_nx;
  logic            pkt_ready_nx;
  logic            chk_err_nx;
  logic            len_err_nx;
  logic            timeout_err_nx;
  logic            drop_nx;
  logic            buf_we;

  logic            in_packet;
  logic            len_ok;
  logic            last_payload;

  // Payload storage; deliberately not reset.
  logic [7:0]      buf_mem [MAX_LEN];

  assign in_packet    = (state_q == GET_LEN) || (state_q == GET_PAYLOAD) ||
                        (state_q == GET_CHK);
  assign len_ok       = ({1'b0, byte_in} != 9'd0) && ({1'b0, byte_in} <= MAX_LEN_B);
  assign last_payload = (LW'(idx_q) == (len_q - LW'(1)));

  // Reads beyond the held length return zero so stale bytes never leak out.
  assign rd_data = (LW'(rd_addr) < pkt_len) ? buf_mem[rd_addr] : 8'h00;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Framing datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q       <= '0;
      idx_q       <= '0;
      chk_q       <= '0;
      cnt_q       <= '0;
      pkt_len     <= '0;
      pkt_ready   <= 1'b0;
      chk_err     <= 1'b0;
      len_err     <= 1'b0;
      timeout_err <= 1'b0;
      drop        <= 1'b0;
    end else begin
      len_q       <= len_nx;
      idx_q       <= idx_nx;
      chk_q       <= chk_nx;
      cnt_q       <= cnt_nx;
      pkt_len     <= pkt_len_nx;
      pkt_ready   <= pkt_ready_nx;
      chk_err     <= chk_err_nx;
      len_err     <= len_err_nx;
      timeout_err <= timeout_err_nx;
      drop        <= drop_nx;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[idx_q] <= byte_in;
    end
  end

  // Next-state, datapath updates and error pulse generation.
  always_comb begin
    state_nx       = state_q;
    len_nx         = len_q;
    idx_nx         = idx_q;
    chk_nx         = chk_q;
    cnt_nx         = cnt_q;
    pkt_len_nx     = pkt_len;
    pkt_ready_nx   = pkt_ready;
    chk_err_nx     = 1'b0;
    len_err_nx     = 1'b0;
    timeout_err_nx = 1'b0;
    drop_nx        = 1'b0;
    buf_we         = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_nx = '0;
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_nx = GET_LEN;
        end
      end

      GET_LEN: begin
        // A LEN byte equal to SYNC is a length, never a resync.
        if (byte_valid) begin
          cnt_nx = '0;
          if (len_ok) begin
            len_nx   = byte_in[LW-1:0];
            chk_nx   = byte_in;
            idx_nx   = '0;
            state_nx = GET_PAYLOAD;
          end else begin
            len_err_nx = 1'b1;
            state_nx   = IDLE;
          end
        end
      end

      GET_PAYLOAD: begin
        if (byte_valid) begin
          cnt_nx = '0;
          buf_we = 1'b1;
          chk_nx = chk_q ^ byte_in;
          idx_nx = idx_q + AW'(1);
          if (last_payload) begin
            state_nx = GET_CHK;
          end
        end
      end

      GET_CHK: begin
        if (byte_valid) begin
          cnt_nx = '0;
          if (byte_in == chk_q) begin
            pkt_len_nx   = len_q;
            pkt_ready_nx = 1'b1;
            state_nx     = HOLD;
          end else begin
            chk_err_nx = 1'b1;
            state_nx   = IDLE;
          end
        end
      end

      HOLD: begin
        cnt_nx = '0;
        if (byte_valid) begin
          drop_nx = 1'b1;
        end
        if (pkt_ack) begin
          pkt_ready_nx = 1'b0;
          state_nx     = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Inter-byte timeout; a byte in the same cycle always wins.
    if (in_packet && !byte_valid) begin
      if (cnt_q == CNT_LAST) begin
        timeout_err_nx = 1'b1;
        cnt_nx         = '0;
        state_nx       = IDLE;
      end else begin
        cnt_nx = cnt_q + CW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_packet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_packet_ctrl
//  Description : Scoreboard bench for rx_packet_ctrl. A byte-stream reference
//                model predicts the output events of each clock edge; a
//                monitor compares them with what the DUT presents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_packet_ctrl;

  localparam int         MAXL = 16;
  localparam int         TOC  = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  // Event bit positions in the observed / expected vectors.
  localparam int K_DROP = 0;
  localparam int K_TO   = 1;
  localparam int K_LEN  = 2;
  localparam int K_CHK  = 3;
  localparam int K_FALL = 4;
  localparam int K_PKT  = 5;

  logic       clk        = 1'b0;
  logic       reset      = 1'b0;
  logic [7:0] byte_in    = 8'h00;
  logic       byte_valid = 1'b0;
  logic [3:0] rd_addr    = 4'd0;
  logic [7:0] rd_data;
  logic [4:0] pkt_len;
  logic       pkt_ready;
  logic       pkt_ack    = 1'b0;
  logic       chk_err;
  logic       len_err;
  logic       timeout_err;
  logic       drop;

  rx_packet_ctrl #(
    .SYNC_BYTE      (SYNC),
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .pkt_len     (pkt_len),
    .pkt_ready   (pkt_ready),
    .pkt_ack     (pkt_ack),
    .chk_err     (chk_err),
    .len_err     (len_err),
    .timeout_err (timeout_err),
    .drop        (drop)
  );

  always #20 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int                at_edge;
    int                kind;
    int                len;
    logic [MAXL*8-1:0] pl;
  } ev_t;

  ev_t exp_q[$];

  task automatic expect_ev(input int kind, input int len, input logic [MAXL*8-1:0] pl);
    ev_t e;
    e.at_edge = edge_cnt + 1;
    e.kind    = kind;
    e.len     = len;
    e.pl      = pl;
    exp_q.push_back(e);
  endtask

  // ---------------- reference model ----------------
  // Bytes seen since SYNC (LEN, payload..., CHK) plus hold / gap bookkeeping.
  bit         m_hold  = 1'b0;
  bit         m_inpkt = 1'b0;
  int         m_gap   = 0;
  logic [7:0] m_pkt[$];

  task automatic model_edge(input bit bv, input logic [7:0] b, input bit ak);
    int                l;
    logic [7:0]        x;
    logic [MAXL*8-1:0] pl;
    if (m_hold) begin
      if (bv) expect_ev(K_DROP, 0, '0);
      if (ak) begin
        m_hold = 1'b0;
        expect_ev(K_FALL, 0, '0);
      end
    end else if (!m_inpkt) begin
      if (bv && b == SYNC) begin
        m_inpkt = 1'b1;
        m_pkt.delete();
        m_gap = 0;
      end
    end else if (bv) begin
      m_gap = 0;
      m_pkt.push_back(b);
      l = int'(m_pkt[0]);
      if (m_pkt.size() == 1) begin
        if (l == 0 || l > MAXL) begin
          expect_ev(K_LEN, 0, '0);
          m_inpkt = 1'b0;
        end
      end else if (m_pkt.size() == l + 2) begin
        x  = 8'h00;
        pl = '0;
        for (int i = 0; i <= l; i++) x ^= m_pkt[i];
        for (int i = 0; i < l; i++) pl[i*8 +: 8] = m_pkt[i+1];
        if (x == b) begin
          expect_ev(K_PKT, l, pl);
          m_hold = 1'b1;
        end else begin
          expect_ev(K_CHK, 0, '0);
        end
        m_inpkt = 1'b0;
      end
    end else begin
      m_gap++;
      if (m_gap == TOC - 1) begin
        expect_ev(K_TO, 0, '0);
        m_inpkt = 1'b0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit bv, input logic [7:0] b, input bit ak);
    byte_valid = bv;
    byte_in    = b;
    pkt_ack    = ak;
    model_edge(bv, b, ak);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    pkt_ack    = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send_pkt(input int len, input int gapmax, input bit corrupt);
    logic [7:0] x;
    logic [7:0] b;
    send(SYNC);
    send(8'(len));
    x = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      idle($urandom_range(0, gapmax));
      send(b);
      x ^= b;
    end
    idle($urandom_range(0, gapmax));
    if (corrupt) x ^= 8'(1 << $urandom_range(0, 7));
    send(x);
  endtask

  task automatic release_pkt();
    repeat ($urandom_range(0, 3)) step(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    step(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pkt_ready"},   pkt_ready,   0);
    chk({tag, "_pkt_len"},     pkt_len,     0);
    chk({tag, "_chk_err"},     chk_err,     0);
    chk({tag, "_len_err"},     len_err,     0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
    chk({tag, "_drop"},        drop,        0);
  endtask

  // ---------------- monitor ----------------
  logic [5:0]        obs;
  logic [5:0]        expv;
  logic              prev_ready = 1'b0;
  ev_t               ev;
  int                exp_len;
  logic [MAXL*8-1:0] exp_pl;
  int                last_len = 0;
  logic [MAXL*8-1:0] last_pl  = '0;

  task automatic check_payload(input int len, input logic [MAXL*8-1:0] pl, input string tag);
    for (int a = 0; a < MAXL; a++) begin
      rd_addr = 4'(a);
      #1;
      chk($sformatf("%s_rd_data[%0d]", tag, a), rd_data, (a < len) ? pl[a*8 +: 8] : 8'h00);
    end
    rd_addr = 4'd0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      obs = '0;
      obs[K_PKT]  = pkt_ready & ~prev_ready;
      obs[K_FALL] = ~pkt_ready & prev_ready;
      obs[K_CHK]  = chk_err;
      obs[K_LEN]  = len_err;
      obs[K_TO]   = timeout_err;
      obs[K_DROP] = drop;
      prev_ready  = pkt_ready;
      expv        = '0;
      exp_len     = 0;
      exp_pl      = '0;
      while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
        ev = exp_q.pop_front();
        expv[ev.kind] = 1'b1;
        if (ev.kind == K_PKT) begin
          exp_len = ev.len;
          exp_pl  = ev.pl;
        end
      end
      if ((obs | expv) != 6'd0) begin
        chk("events", 32'(obs), 32'(expv));
        if (expv[K_PKT]) begin
          chk("pkt_len", pkt_len, exp_len);
          check_payload(exp_len, exp_pl, "held");
          last_len = exp_len;
          last_pl  = exp_pl;
        end
        if (expv[K_FALL]) begin
          // Buffer must still hold the released packet untouched by drops.
          check_payload(last_len, last_pl, "released");
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic [7:0] b;
    int         kind;
    int         len;
    int         k;

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Good packet A5 03 11 22 33 03.
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    idle(2);
    step(1'b0, 8'h00, 1'b1);
    idle(2);

    // Ack while nothing is held is ignored.
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Bad checksum, then a good packet.
    send(SYNC); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    idle(1);
    send_pkt(3, 0, 1'b0);
    release_pkt();

    // Length bounds.
    send(SYNC); send(8'h00);
    idle(1);
    send(SYNC); send(8'h11);
    idle(1);
    send(SYNC); send(SYNC);
    idle(1);
    send_pkt(16, 0, 1'b0);
    release_pkt();

    // Timeout: 99 idle cycles after the last byte.
    send(SYNC); send(8'h02); send(8'h11);
    idle(99);
    idle(3);
    // Next byte lands on the 99th idle cycle: no timeout.
    send(SYNC); send(8'h02); send(8'h11);
    idle(98);
    send(8'h5C);
    send(8'h02 ^ 8'h11 ^ 8'h5C);
    idle(1);
    release_pkt();

    // Hold / backpressure.
    send_pkt(5, 1, 1'b0);
    send(SYNC); send(8'h01); send(8'h07); send(8'h06);
    step(1'b1, SYNC, 1'b1);
    send_pkt(2, 0, 1'b0);
    release_pkt();

    // Reset in the middle of a packet.
    send(SYNC); send(8'h03); send(8'h11);
    reset = 1'b0;
    m_inpkt = 1'b0;
    m_hold  = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("mid_reset");
    reset = 1'b1;
    idle(2);
    send_pkt(3, 0, 1'b0);
    release_pkt();

    // Randomized traffic.
    for (int p = 0; p < 60; p++) begin
      repeat ($urandom_range(0, 2)) send(8'($urandom));
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, MAXL);
      if (kind == 0) begin
        case ($urandom_range(0, 2))
          0:       b = 8'h00;
          1:       b = 8'(MAXL + 1 + $urandom_range(0, 5));
          default: b = SYNC;
        endcase
        send(SYNC);
        send(b);
      end else if (kind == 1) begin
        send_pkt(len, 2, 1'b1);
      end else if (kind == 2) begin
        send(SYNC);
        k = $urandom_range(0, len + 1);
        if (k > 0) send(8'(len));
        for (int i = 1; i < k; i++) send(8'($urandom));
        idle(TOC - 1 + $urandom_range(0, 2));
      end else begin
        send_pkt(len, 2, 1'b0);
      end
      idle($urandom_range(0, 2));
      if (m_hold) release_pkt();
    end

    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_packet_ctrl.md
# rx_packet_ctrl

Framing controller that sits directly after the UART receiver. It consumes the receiver's byte stream and recognises packets of the form SYNC, LEN, PAYLOAD[LEN], CHK. It stores the payload in an internal buffer and presents each verified packet to the command logic with a ready/ack handshake. Bad length, bad checksum and inter-byte timeout each abort the packet and return the block to hunting for SYNC.

## Interface
- SYNC_BYTE, 8'hA5, start-of-packet marker.
- MAX_LEN, 16, maximum payload bytes; buffer depth.
- TIMEOUT_CYCLES, 1_000_000, clk cycles allowed between bytes inside a packet.
- LW, $clog2(MAX_LEN+1), derived width of length fields; not for override.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- byte_in  in  8  received byte from the UART receiver.
- byte_valid  in  1  one-cycle pulse; byte_in is valid in that cycle.
- rd_addr  in  $clog2(MAX_LEN)  payload buffer read index.
- rd_data  out  8  payload byte at rd_addr; combinational.
- pkt_len  out  LW  payload length of the held packet.
- pkt_ready  out  1  a verified packet is held.
- pkt_ack  in  1  consumer releases the held packet.
- chk_err  out  1  one-cycle pulse on checksum mismatch.
- len_err  out  1  one-cycle pulse on LEN == 0 or LEN > MAX_LEN.
- timeout_err  out  1  one-cycle pulse on inter-byte timeout.
- drop  out  1  one-cycle pulse when a byte arrives while a packet is held.

## Operation
- The FSM has five states: IDLE, GET_LEN, GET_PAYLOAD, GET_CHK and HOLD.
- IDLE:
  - byte_valid with byte_in == SYNC_BYTE -> GET_LEN.
  - Any other byte is ignored silently.
- GET_LEN:
  - If 1 <= byte_in <= MAX_LEN: latch len, set chk_acc = byte_in and idx = 0, go to GET_PAYLOAD.
  - Otherwise pulse len_err and go to IDLE.
  - A LEN byte equal to SYNC_BYTE is treated as a length, not as a resync.
- GET_PAYLOAD:
  - Each byte is written to buf[idx]; chk_acc ^= byte_in; idx++.
  - When idx == len-1 is written, go to GET_CHK.
- GET_CHK:
  - If byte_in == chk_acc: set pkt_len = len, assert pkt_ready, go to HOLD.
  - Otherwise pulse chk_err and go to IDLE.
- The checksum is the 8-bit XOR of LEN and all payload bytes; SYNC is excluded.
- HOLD:
  - The buffer is frozen and pkt_ready is held at 1.
  - A byte_valid pulses drop; the byte is discarded.
  - pkt_ack -> go to IDLE and clear pkt_ready.
- Timeout:
  - A cycle counter runs only in GET_LEN, GET_PAYLOAD and GET_CHK.
  - It clears on entry to those states and on every byte_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no byte: pulse timeout_err and go to IDLE.
  - A byte_valid in that same cycle wins: the byte is processed and no timeout occurs.
- rd_data:
  - rd_data = buf[rd_addr] when rd_addr < pkt_len, else 8'h00.
  - It is meaningful only while pkt_ready == 1.
- After any error, a partially written buffer is never exposed, because pkt_len only updates on a good checksum.

## Timing
- Reset asserted: state = IDLE. All of the following are 0:
  - outputs pkt_ready, pkt_len, chk_err, len_err, timeout_err, drop;
  - internal len, idx, chk_acc, timeout counter.
- Buffer contents are not reset. rd_data is therefore 8'h00 after reset, because pkt_len == 0.
- Reset asserted mid-packet aborts the packet immediately; no error pulse is generated.
- Every byte is consumed in the cycle its byte_valid is high. Back-to-back byte_valid pulses on consecutive cycles are supported.
- Latency: pkt_ready rises on the clk edge that samples byte_valid with the correct CHK byte, one cycle after the CHK pulse.
- Error pulses are registered, are exactly one cycle wide, and are asserted the cycle after the offending byte or the timeout event.
- Handshake:
  - pkt_ready falls on the edge that samples pkt_ack == 1.
  - pkt_ack while pkt_ready == 0 is ignored.
- A byte_valid in the same cycle as pkt_ack while in HOLD is dropped and pulses drop. The first accepted byte is the one after pkt_ready falls.
- No throughput limit is imposed beyond one byte per cycle.

## Test plan
- Good packet: bytes A5 03 11 22 33 03.
  - Required: pkt_ready=1 one cycle after the last byte, pkt_len=3.
  - Reading rd_addr 0/1/2/3 returns 11/22/33/00.
  - pkt_ack clears pkt_ready next cycle.
- Bad checksum: A5 03 11 22 33 04 -> chk_err one-cycle pulse, pkt_ready stays 0. A following good packet is accepted.
- Length bounds, each of which must pulse len_err and return to IDLE:
  - A5 00;
  - A5 11 (17, with MAX_LEN=16).
  - A5 10 plus 16 bytes plus a correct CHK gives pkt_len=16.
- Timeout, with TIMEOUT_CYCLES=100:
  - A5 02 11 followed by 99 idle cycles -> timeout_err.
  - The same stimulus with the next byte arriving exactly on the 99th idle cycle -> no error.
- Hold/backpressure: while pkt_ready is held, send A5 01 07 06 -> four drop pulses and rd_data unchanged. Send a packet after pkt_ack -> it is accepted.
- Reset mid-packet: A5 03 11, then assert reset for 2 cycles -> all outputs 0 and no error pulse. The next full packet is accepted normally.
